// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding four byte requesters into a single UART transmitter.
// Handshakes with the UART through a synchronized tx_rdy and a registered strobe.
module uart_tx_arbiter #(
  parameter int unsigned STB_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic [3:0] req,
  input  logic [7:0] req_byte0,
  input  logic [7:0] req_byte1,
  input  logic [7:0] req_byte2,
  input  logic [7:0] req_byte3,
  output logic [3:0] ack,
  output logic       err,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic [7:0] tx_byte,
  output logic       stb,
  input  logic       tx_rdy
);

  localparam int CNT_W = $clog2(STB_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STB_TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_BUSY   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic             rdy_m;
  logic             rdy_s;
  logic [1:0]       next_start;
  logic [CNT_W-1:0] stb_cnt;
  logic [3:0]       rr_mask;
  logic [3:0]       masked;
  logic [1:0]       winner;
  logic [7:0]       winner_byte;
  logic [3:0]       grant_onehot;

  function automatic logic [1:0] first_one(input logic [3:0] v);
    casez (v)
      4'b???1: first_one = 2'd0;
      4'b??10: first_one = 2'd1;
      4'b?100: first_one = 2'd2;
      default: first_one = 2'd3;
    endcase
  endfunction

  // tx_rdy comes from the UART clock domain; reset value 1 means "idle".
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rdy_m <= 1'b1;
      rdy_s <= 1'b1;
    end else begin
      rdy_m <= tx_rdy;
      rdy_s <= rdy_m;
    end
  end

  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    rr_mask = 4'b1111 << next_start;
    masked  = req & rr_mask;
    winner  = (masked != 4'b0000) ? first_one(masked) : first_one(req);
    case (winner)
      2'd0:    winner_byte = req_byte0;
      2'd1:    winner_byte = req_byte1;
      2'd2:    winner_byte = req_byte2;
      default: winner_byte = req_byte3;
    endcase
  end

  assign grant_onehot = 4'b0001 << grant_id;

  // Separate pointer so the first search after reset starts at 0 although grant_id is also 0.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state      <= S_IDLE;
      stb        <= 1'b0;
      tx_byte    <= 8'h00;
      ack        <= 4'b0000;
      err        <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= 2'd0;
      next_start <= 2'd0;
      stb_cnt    <= '0;
    end else begin
      ack <= 4'b0000;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if ((req != 4'b0000) && rdy_s) begin
            tx_byte    <= winner_byte;
            grant_id   <= winner;
            next_start <= winner + 2'd1;
            stb        <= 1'b1;
            busy       <= 1'b1;
            stb_cnt    <= '0;
            state      <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (!rdy_s) begin
            stb   <= 1'b0;
            ack   <= grant_onehot;
            state <= S_BUSY;
          end else if (stb_cnt == CNT_MAX) begin
            stb   <= 1'b0;
            ack   <= grant_onehot;
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            stb_cnt <= stb_cnt + CNT_W'(1);
          end
        end
        S_BUSY: begin
          if (rdy_s) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          stb_cnt <= '0;
          state   <= S_IDLE;
        end
        default: begin
          stb   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  ack_onehot: assert property (@(posedge clk) disable iff (!res_n) $onehot0(ack));
  err_with_ack: assert property (@(posedge clk) disable iff (!res_n) err |-> (ack != 4'b0000));

endmodule
